// File: rtl/peak_rate_detector.sv
// ---------------------------------------------------------------------------
// peak_rate_detector
//
// Purpose:
//   Confirms peaks in a strobed, filtered sample stream by slope-run shape.
//   A peak is armed by MIN_RUN consecutive rising samples and confirmed by
//   MIN_RUN consecutive falling samples. After a confirmation the detector is
//   locked out for REFRACT valid samples. Confirmed peaks are counted over a
//   free-running window of WINDOW_CYCLES clocks. At the end of each window the
//   count, scaled by BPM_MULT, is published as a rate.
//
// Optional feature (macro PEAK_AMP_THRESH_EN):
//   When defined, a shape-confirmed peak is accepted only if its amplitude
//   above the preceding trough is at least MIN_AMP. A rejected peak produces no
//   pulse and no count, and the detector returns to SEEK without a lockout.
//   When undefined, MIN_AMP is ignored.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   sample_valid  in   one-cycle strobe qualifying sample
//   sample        in   [DATA_W-1:0] filtered sample, unsigned
//   peak_pulse    out  one-cycle pulse per accepted peak
//   peak_value    out  [DATA_W-1:0] max sample of the last accepted peak, held
//   peak_count    out  [CNT_W-1:0] accepted peaks in the current window
//   rate          out  [RATE_W-1:0] scaled rate of the last completed window
//   rate_valid    out  one-cycle pulse when rate updates
//   dbg_state     out  [1:0] FSM state (0 IDLE, 1 SEEK, 2 RISING, 3 REFRACT)
//
// Input handshake: sample_valid is a strobe without backpressure. Whenever
// sample_valid is high at a rising clk edge the sample is consumed on that
// edge; the block has no ready signal and never stalls the producer.
// ---------------------------------------------------------------------------
module peak_rate_detector #(
  parameter int DATA_W        = 10,
  parameter int MIN_RUN       = 4,
  parameter int REFRACT       = 50,
  parameter int WINDOW_CYCLES = 400000000,
  parameter int BPM_MULT      = 6,
  parameter int CNT_W         = 8,
  parameter int RATE_W        = 10,
  parameter int MIN_AMP       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              peak_pulse,
  output logic [DATA_W-1:0] peak_value,
  output logic [CNT_W-1:0]  peak_count,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic [1:0]        dbg_state
);

  localparam int RUN_W  = $clog2(MIN_RUN + 1);
  localparam int REF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int MUL_W  = CNT_W + $clog2(BPM_MULT + 1);
  localparam int PROD_W = (MUL_W > RATE_W) ? MUL_W : RATE_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEEK    = 2'd1;
  localparam logic [1:0] ST_RISING  = 2'd2;
  localparam logic [1:0] ST_REFRACT = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] trough;
  logic [DATA_W-1:0] cand;
  logic [RUN_W-1:0]  rise_cnt;
  logic [RUN_W-1:0]  fall_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic [WIN_W-1:0]  win_cnt;

  logic              is_rise;
  logic              is_fall;
  logic              arm;
  logic              shape_ok;
  logic              amp_ok;
  logic              accept;
  logic              win_term;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] rate_max;
  logic [RATE_W-1:0] rate_sat;

  assign dbg_state = state;

  // Equal samples are a plateau: neither rise nor fall, so no run changes.
  assign is_rise = sample > prev;
  assign is_fall = sample < prev;

  // The sample that completes a run acts on the same edge, so the run
  // counters compare against MIN_RUN-1 before incrementing.
  assign arm      = sample_valid && (state == ST_SEEK) && is_rise &&
                    (rise_cnt == RUN_W'(MIN_RUN - 1));
  assign shape_ok = sample_valid && (state == ST_RISING) && is_fall &&
                    (fall_cnt == RUN_W'(MIN_RUN - 1));

`ifdef PEAK_AMP_THRESH_EN
  logic [DATA_W:0] amp;
  assign amp    = {1'b0, cand} - {1'b0, trough};
  assign amp_ok = (cand >= trough) && (amp >= (DATA_W + 1)'(MIN_AMP));
`else
  assign amp_ok = 1'b1;
`endif

  assign accept   = shape_ok && amp_ok;
  assign win_term = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  // Product is formed wide enough for the full count times the multiplier,
  // then clamped to the rate width.
  assign prod     = PROD_W'(peak_count) * PROD_W'(BPM_MULT);
  assign rate_max = PROD_W'({RATE_W{1'b1}});
  assign rate_sat = (prod > rate_max) ? {RATE_W{1'b1}} : prod[RATE_W-1:0];

  // Shape FSM; advances only on valid samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      prev     <= '0;
      trough   <= '0;
      cand     <= '0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      ref_cnt  <= '0;
    end else if (sample_valid) begin
      prev <= sample;
      case (state)
        ST_IDLE: begin
          trough   <= sample;
          rise_cnt <= '0;
          state    <= ST_SEEK;
        end
        ST_SEEK: begin
          if (arm) begin
            state    <= ST_RISING;
            cand     <= sample;
            fall_cnt <= '0;
            rise_cnt <= '0;
          end else if (is_rise) begin
            rise_cnt <= rise_cnt + RUN_W'(1);
          end else if (is_fall) begin
            rise_cnt <= '0;
            if (sample < trough) trough <= sample;
          end
        end
        ST_RISING: begin
          if (is_rise) begin
            if (sample > cand) cand <= sample;
            fall_cnt <= '0;
          end else if (shape_ok) begin
            fall_cnt <= '0;
            if (accept && (REFRACT > 0)) begin
              state   <= ST_REFRACT;
              ref_cnt <= REF_W'(REFRACT);
            end else begin
              // Either no lockout is configured or the peak was too small:
              // restart the search from the current sample.
              state    <= ST_SEEK;
              rise_cnt <= '0;
              trough   <= sample;
            end
          end else if (is_fall) begin
            fall_cnt <= fall_cnt + RUN_W'(1);
          end
        end
        ST_REFRACT: begin
          if (ref_cnt <= REF_W'(1)) begin
            state    <= ST_SEEK;
            ref_cnt  <= '0;
            rise_cnt <= '0;
            trough   <= sample;
          end else begin
            ref_cnt <= ref_cnt - REF_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Peak outputs, window counter and rate publication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_pulse <= 1'b0;
      peak_value <= '0;
      peak_count <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      win_cnt    <= '0;
    end else begin
      peak_pulse <= accept;
      if (accept) peak_value <= cand;

      rate_valid <= win_term;
      if (win_term) begin
        rate    <= rate_sat;
        win_cnt <= '0;
        // A peak landing on the terminal cycle opens the next window.
        peak_count <= accept ? CNT_W'(1) : '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (accept && (peak_count != {CNT_W{1'b1}}))
          peak_count <= peak_count + CNT_W'(1);
      end
    end
  end

endmodule
